mem_align_unit: RTL and testbench
=================================

# mem_align_unit

Load/store alignment stage between the EX/MEM pipeline register and `datamemory`. It passes in-word accesses through unchanged and splits word-crossing accesses into sequences of in-word accesses. Misaligned loads become two LW reads merged into one result; misaligned stores become per-byte SB writes. While a split access is in flight, the block stalls the pipeline. It also owns load byte and halfword extraction and sign extension, so `datamemory` is always read with LW.

## Interface
- DM_ADDRESS, 9, byte-address width into `datamemory`
- DATA_W, 32, data width
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- MemRead_i  in  1  load request from EX/MEM
- MemWrite_i  in  1  store request from EX/MEM
- Funct3_i  in  3  instruction bits 14:12
- Addr_i  in  DM_ADDRESS  byte address (ALU result LSBs)
- WData_i  in  DATA_W  store data
- MemRead_o / MemWrite_o  out  1  to `datamemory` MemRead/MemWrite
- Funct3_o  out  3  to `datamemory` Funct3
- a_o  out  DM_ADDRESS  to `datamemory` a
- wd_o  out  DATA_W  to `datamemory` wd
- rd_i  in  DATA_W  raw word from `datamemory` rd; always an LW result
- RData_o  out  DATA_W  extracted/extended load data to MEM/WB
- RData_valid  out  1  RData_o final this cycle
- stall  out  1  to hazard unit; freezes PC, IF/ID, ID/EX and EX/MEM
- misalign  out  1  current request is being split; status only

## Operation
- off = Addr_i[1:0]. A request is misaligned when it is a halfword (001/101) with off=3, or a word (010 and default) with off≠0. Bytes are never misaligned.
- If MemRead_i and MemWrite_i are both high, the read wins.
- Load funct3 011/110/111 are treated as LW. Store funct3 other than 000/001 are treated as SW.
- Aligned load (IDLE):
  - Drive a_o={Addr_i[8:2],2'b00}, Funct3_o=010, MemRead_o=1.
  - Extract from rd_i by off and funct3: LB/LBU/LH/LHU/LW with sign or zero extension.
  - RData_valid=1, stall=0.
- Aligned store (IDLE): pass Addr_i, Funct3_i and WData_i through unchanged; `datamemory` builds the byte mask.
- Misaligned load, FSM IDLE→LD_HI:
  - IDLE cycle: read word0={A[8:2],00}, latch rd_i into lo_q, latch the request, stall=1.
  - LD_HI cycle: read word1 = word0+4, where the word index wraps mod 2^(DM_ADDRESS-2).
  - Merge {rd_i,lo_q}>>8·off, truncate, extend; RData_valid=1, stall=0; next state IDLE.
- Misaligned store, FSM IDLE→ST_BYTE:
  - Latch the request and set n = 2 (SH) or 4 (SW).
  - Issue n SB writes at byte addresses A+i, wrapping mod 2^DM_ADDRESS, with wd_o[7:0]=WData[8i+7:8i], for i=0..n-1.
  - The counter cnt_q counts 0..n-1. stall=1 until cnt_q=n-1; ST_BYTE returns to IDLE after the last byte.
- In LD_HI/ST_BYTE the block works from latched copies only; pipeline inputs are ignored.
- States: IDLE, LD_HI, ST_BYTE.

## Timing
- Reset values: state=IDLE, cnt_q=0, lo_q=0. During a reset cycle, all outputs are 0 (MemRead_o, MemWrite_o, stall, RData_valid, misalign, RData_o).
- Reset mid-sequence aborts it. Bytes already written stay written; the next cycle is IDLE.
- Aligned access: 0 extra cycles, combinational pass-through, RData_o valid in the same cycle.
- Misaligned load: 2 cycles; stall pattern 1,0.
- Misaligned SH: 2 cycles; misaligned SW: 4 cycles. stall is high on all but the last cycle.
- misalign is high on every cycle of a split sequence, including the last.
- A new request is accepted only in IDLE; the cycle after the final split cycle can take a new request.

## Structure
- mem_align_pkg:
  - state_t enum {IDLE, LD_HI, ST_BYTE}
  - localparams for F3_LB/LH/LW/LBU/LHU/SB/SH/SW
  - function is_misaligned(funct3, off)
- Sub-module load_extract: combinational; inputs 64-bit {hi,lo}, off and funct3; output 32-bit extended data. Used by both the aligned path (hi=0) and the merged path.

## Test plan
- Memory 0x10=0x44332211, 0x14=0x88776655.
  - LW @0x11 → stall 1,0; reads at 0x10 then 0x14; RData_o=0x55443322.
  - LB @0x17 → no stall; RData_o=0xFFFFFF88.
  - LBU @0x12 → RData_o=0x00000033.
- 0x18=0x000000AA; LH @0x17 → 2 cycles; RData_o=0xFFFFAA88. LHU @0x17 → 0x0000AA88.
- SW 0xDEADBEEF @0x1FE → SB writes: EF@0x1FE, BE@0x1FF, AD@0x000, DE@0x001; stall 1,1,1,0. Readback LW @0x1FC=0xBEEFxxxx and @0x000=0xxxxxDEAD.
- SH 0x1234 @0x13 → SB 0x34@0x13, 0x12@0x14; stall 1,0. SH @0x12 → single SH pass-through, no stall.
- Reset asserted in the 2nd cycle of a misaligned SW → only byte 0 written; outputs 0 during reset; next cycle IDLE, stall=0.
- MemRead_i=MemWrite_i=1 with LW @0x10 → read performed, MemWrite_o=0, RData_o=0x44332211.

Source files
------------

// File: rtl/mem_align_pkg.sv
// Shared types and decode helpers for the load/store alignment stage.
// Split accesses are sequenced by state_t; funct3 codes follow RV32I.
package mem_align_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LD_HI,
        ST_BYTE
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Bytes never cross a word; halfwords only from offset 3.
    function automatic logic is_misaligned(
        input logic [2:0] funct3,
        input logic [1:0] off
    );
        case (funct3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return off == 2'd3;
            default:       return off != 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align_unit_load_extract.sv
// Load data extraction: shifts a {hi,lo} word pair by the byte offset,
// then truncates and sign/zero extends according to funct3.
module load_extract
    import mem_align_pkg::*;
(
    input  logic [63:0] i_data,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_sh;

    assign w_sh = 32'(i_data >> {i_off, 3'b000});

    always_comb begin
        unique case (i_funct3)
            F3_LB:   o_data = {{24{w_sh[7]}}, w_sh[7:0]};
            F3_LBU:  o_data = {24'd0, w_sh[7:0]};
            F3_LH:   o_data = {{16{w_sh[15]}}, w_sh[15:0]};
            F3_LHU:  o_data = {16'd0, w_sh[15:0]};
            default: o_data = w_sh;
        endcase
    end

endmodule

// File: rtl/mem_align_unit.sv
// Alignment stage between EX/MEM and datamemory: passes in-word accesses,
// splits word-crossing loads into two LW reads and stores into SB writes.
module mem_align_unit
    import mem_align_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [2:0]            Funct3_i,
    input  logic [DM_ADDRESS-1:0] Addr_i,
    input  logic [DATA_W-1:0]     WData_i,
    output logic                  MemRead_o,
    output logic                  MemWrite_o,
    output logic [2:0]            Funct3_o,
    output logic [DM_ADDRESS-1:0] a_o,
    output logic [DATA_W-1:0]     wd_o,
    input  logic [DATA_W-1:0]     rd_i,
    output logic [DATA_W-1:0]     RData_o,
    output logic                  RData_valid,
    output logic                  stall,
    output logic                  misalign
);

    localparam int WI = DM_ADDRESS - 2;

    state_t                r_state;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [2:0]            r_f3;
    logic [DATA_W-1:0]     r_data;
    logic [DATA_W-1:0]     r_lo;
    logic [1:0]            r_cnt;
    logic [1:0]            r_last;

    logic [1:0]  w_off;
    logic        w_rd;
    logic        w_wr;
    logic [2:0]  w_st_f3;
    logic        w_mis_ld;
    logic        w_mis_st;
    logic [WI-1:0] w_widx_hi;
    logic [63:0] w_ext_in;
    logic [1:0]  w_ext_off;
    logic [2:0]  w_ext_f3;
    logic [31:0] w_ext_out;

    assign w_off   = Addr_i[1:0];
    assign w_rd    = MemRead_i;
    assign w_wr    = MemWrite_i & ~MemRead_i;
    // Unknown store widths are handled as full words.
    assign w_st_f3 = (Funct3_i == F3_SB || Funct3_i == F3_SH) ? Funct3_i : F3_SW;
    assign w_mis_ld  = w_rd & is_misaligned(Funct3_i, w_off);
    assign w_mis_st  = w_wr & is_misaligned(w_st_f3, w_off);
    assign w_widx_hi = r_addr[DM_ADDRESS-1:2] + WI'(1);

    always_comb begin
        w_ext_in  = {32'd0, rd_i};
        w_ext_off = w_off;
        w_ext_f3  = Funct3_i;
        if (r_state == LD_HI) begin
            w_ext_in  = {rd_i, r_lo};
            w_ext_off = r_addr[1:0];
            w_ext_f3  = r_f3;
        end
    end

    load_extract u_extract (
        .i_data   (w_ext_in),
        .i_off    (w_ext_off),
        .i_funct3 (w_ext_f3),
        .o_data   (w_ext_out)
    );

    always_comb begin
        MemRead_o   = 1'b0;
        MemWrite_o  = 1'b0;
        Funct3_o    = 3'd0;
        a_o         = '0;
        wd_o        = '0;
        RData_o     = '0;
        RData_valid = 1'b0;
        stall       = 1'b0;
        misalign    = 1'b0;
        if (!reset) begin
            unique case (r_state)
                IDLE: begin
                    if (w_rd) begin
                        MemRead_o   = 1'b1;
                        Funct3_o    = F3_LW;
                        a_o         = {Addr_i[DM_ADDRESS-1:2], 2'b00};
                        stall       = w_mis_ld;
                        misalign    = w_mis_ld;
                        RData_valid = ~w_mis_ld;
                        RData_o     = w_mis_ld ? '0 : w_ext_out;
                    end else if (w_wr) begin
                        MemWrite_o = 1'b1;
                        a_o        = Addr_i;
                        stall      = w_mis_st;
                        misalign   = w_mis_st;
                        if (w_mis_st) begin
                            Funct3_o = F3_SB;
                            wd_o     = {{(DATA_W-8){1'b0}}, WData_i[7:0]};
                        end else begin
                            Funct3_o = Funct3_i;
                            wd_o     = WData_i;
                        end
                    end
                end
                LD_HI: begin
                    MemRead_o   = 1'b1;
                    Funct3_o    = F3_LW;
                    a_o         = {w_widx_hi, 2'b00};
                    RData_o     = w_ext_out;
                    RData_valid = 1'b1;
                    misalign    = 1'b1;
                end
                ST_BYTE: begin
                    MemWrite_o = 1'b1;
                    Funct3_o   = F3_SB;
                    a_o        = r_addr + DM_ADDRESS'(r_cnt);
                    wd_o       = {{(DATA_W-8){1'b0}}, r_data[{r_cnt, 3'b000} +: 8]};
                    stall      = r_cnt != r_last;
                    misalign   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Byte 0 of a split store is issued from IDLE, so ST_BYTE starts at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
            r_last  <= 2'd0;
            r_lo    <= '0;
            r_addr  <= '0;
            r_f3    <= 3'd0;
            r_data  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_mis_ld) begin
                        r_state <= LD_HI;
                        r_lo    <= rd_i;
                        r_addr  <= Addr_i;
                        r_f3    <= Funct3_i;
                    end else if (w_mis_st) begin
                        r_state <= ST_BYTE;
                        r_cnt   <= 2'd1;
                        r_last  <= (w_st_f3 == F3_SH) ? 2'd1 : 2'd3;
                        r_addr  <= Addr_i;
                        r_data  <= WData_i;
                    end
                end
                LD_HI: r_state <= IDLE;
                ST_BYTE: begin
                    if (r_cnt == r_last) begin
                        r_state <= IDLE;
                        r_cnt   <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_align_unit.sv
// Self-checking bench for mem_align_unit with a byte-array datamemory
// and a byte-level reference model of loads, stores and cycle counts.
module tb_mem_align_unit;

    logic        clk;
    logic        reset;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [2:0]  Funct3_i;
    logic [8:0]  Addr_i;
    logic [31:0] WData_i;
    logic        MemRead_o;
    logic        MemWrite_o;
    logic [2:0]  Funct3_o;
    logic [8:0]  a_o;
    logic [31:0] wd_o;
    logic [31:0] rd_i;
    logic [31:0] RData_o;
    logic        RData_valid;
    logic        stall;
    logic        misalign;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] mem  [512];
    logic [7:0] img  [512];
    logic [7:0] refm [512];
    logic       load_img;

    mem_align_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .Funct3_i    (Funct3_i),
        .Addr_i      (Addr_i),
        .WData_i     (WData_i),
        .MemRead_o   (MemRead_o),
        .MemWrite_o  (MemWrite_o),
        .Funct3_o    (Funct3_o),
        .a_o         (a_o),
        .wd_o        (wd_o),
        .rd_i        (rd_i),
        .RData_o     (RData_o),
        .RData_valid (RData_valid),
        .stall       (stall),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wsize(input logic [2:0] f);
        case (f)
            3'b000:  return 1;
            3'b001:  return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int lsize(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // datamemory stand-in: reads whole words, writes size bytes at a_o
    always_comb begin
        rd_i = {mem[{a_o[8:2], 2'b11}], mem[{a_o[8:2], 2'b10}],
                mem[{a_o[8:2], 2'b01}], mem[{a_o[8:2], 2'b00}]};
    end

    always @(posedge clk) begin
        if (load_img) begin
            mem <= img;
        end else if (MemWrite_o) begin
            for (int i = 0; i < 4; i++)
                if (i < wsize(Funct3_o))
                    mem[a_o + 9'(i)] <= wd_o[8*i +: 8];
        end
    end

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [8:0] a);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = lsize(f);
        for (int i = 0; i < n; i++)
            v = v | (32'(refm[(int'(a) + i) % 512]) << (8 * i));
        if (f == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (f == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f, input logic [8:0] a, input logic [31:0] d);
        for (int i = 0; i < wsize(f); i++)
            refm[(int'(a) + i) % 512] = d[8*i +: 8];
    endtask

    // An access takes one cycle unless its bytes straddle a word boundary.
    function automatic int exp_cycles(input logic rd, input logic wr,
                                      input logic [2:0] f, input logic [8:0] a);
        int o;
        o = int'(a[1:0]);
        if (rd) return (o + lsize(f) > 4) ? 2 : 1;
        if (wr) return (o + wsize(f) > 4) ? wsize(f) : 1;
        return 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic mem_cmp(input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < 512; i++)
            if (mem[i] !== refm[i]) bad++;
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s/mem: %0d bytes differ, expected 0", nm, bad);
        end
    endtask

    // Called at a negedge; returns at a negedge with inputs idle.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [8:0] a, input logic [31:0] wd,
                          input int exp_cyc, input logic [31:0] exp_rd,
                          input string nm);
        int cyc;
        bit done;
        logic [31:0] got;
        logic gotv;
        MemRead_i  = rd;
        MemWrite_i = wr;
        Funct3_i   = f3;
        Addr_i     = a;
        WData_i    = wd;
        cyc  = 0;
        done = 0;
        got  = 32'd0;
        gotv = 1'b0;
        while (!done && cyc < 8) begin
            #1;
            cyc++;
            chk({nm, "/stall"}, 32'(stall), 32'(cyc < exp_cyc));
            chk({nm, "/misalign"}, 32'(misalign), 32'(exp_cyc > 1));
            if (rd) chk({nm, "/memwrite"}, 32'(MemWrite_o), 32'd0);
            if (!stall) begin
                done = 1;
                got  = RData_o;
                gotv = RData_valid;
            end
            @(negedge clk);
            if (!done) begin
                MemRead_i  = 1'($urandom);
                MemWrite_i = 1'($urandom);
                Funct3_i   = 3'($urandom);
                Addr_i     = 9'($urandom);
                WData_i    = $urandom;
            end
        end
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        chk({nm, "/cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({nm, "/valid"}, 32'(gotv), 32'(rd));
        if (rd) chk({nm, "/rdata"}, got, exp_rd);
        if (wr && !rd) begin
            ref_store(f3, a, wd);
            mem_cmp(nm);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "/MemRead_o"}, 32'(MemRead_o), 32'd0);
        chk({nm, "/MemWrite_o"}, 32'(MemWrite_o), 32'd0);
        chk({nm, "/stall"}, 32'(stall), 32'd0);
        chk({nm, "/RData_valid"}, 32'(RData_valid), 32'd0);
        chk({nm, "/misalign"}, 32'(misalign), 32'd0);
        chk({nm, "/RData_o"}, RData_o, 32'd0);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [8:0]  a;
        logic [31:0] wd;
        int          cyc;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 19;
    vec_t tv [NV];

    initial begin
        tv[0]  = '{1'b1, 1'b0, 3'b010, 9'h011, 32'h0,        2, 32'h5544_3322};
        tv[1]  = '{1'b1, 1'b0, 3'b000, 9'h017, 32'h0,        1, 32'hFFFF_FF88};
        tv[2]  = '{1'b1, 1'b0, 3'b100, 9'h012, 32'h0,        1, 32'h0000_0033};
        tv[3]  = '{1'b1, 1'b0, 3'b001, 9'h017, 32'h0,        2, 32'hFFFF_AA88};
        tv[4]  = '{1'b1, 1'b0, 3'b101, 9'h017, 32'h0,        2, 32'h0000_AA88};
        tv[5]  = '{1'b1, 1'b1, 3'b010, 9'h010, 32'hDEAD_DEAD, 1, 32'h4433_2211};
        tv[6]  = '{1'b0, 1'b1, 3'b010, 9'h1FE, 32'hDEAD_BEEF, 4, 32'h0};
        tv[7]  = '{1'b1, 1'b0, 3'b010, 9'h1FC, 32'h0,        1, 32'hBEEF_0000};
        tv[8]  = '{1'b1, 1'b0, 3'b010, 9'h000, 32'h0,        1, 32'h0000_DEAD};
        tv[9]  = '{1'b1, 1'b0, 3'b010, 9'h1FF, 32'h0,        2, 32'h00DE_ADBE};
        tv[10] = '{1'b0, 1'b1, 3'b001, 9'h013, 32'h0000_1234, 2, 32'h0};
        tv[11] = '{1'b1, 1'b0, 3'b010, 9'h010, 32'h0,        1, 32'h3433_2211};
        tv[12] = '{1'b1, 1'b0, 3'b010, 9'h014, 32'h0,        1, 32'h8877_6612};
        tv[13] = '{1'b0, 1'b1, 3'b001, 9'h012, 32'h0000_ABCD, 1, 32'h0};
        tv[14] = '{1'b1, 1'b0, 3'b010, 9'h010, 32'h0,        1, 32'hABCD_2211};
        tv[15] = '{1'b1, 1'b0, 3'b011, 9'h012, 32'h0,        2, 32'h6612_ABCD};
        tv[16] = '{1'b0, 1'b1, 3'b000, 9'h003, 32'h0000_0077, 1, 32'h0};
        tv[17] = '{1'b1, 1'b0, 3'b000, 9'h003, 32'h0,        1, 32'h0000_0077};
        tv[18] = '{1'b1, 1'b0, 3'b000, 9'h000, 32'h0,        1, 32'hFFFF_FFAD};

        for (int i = 0; i < 512; i++) refm[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            refm[i] = 8'h00;
            refm[508 + i] = 8'h00;
        end
        for (int i = 0; i < 4; i++) begin
            refm[16 + i] = 8'(32'h4433_2211 >> (8 * i));
            refm[20 + i] = 8'(32'h8877_6655 >> (8 * i));
            refm[24 + i] = 8'(32'h0000_00AA >> (8 * i));
        end
        img = refm;

        reset      = 1'b1;
        load_img   = 1'b1;
        MemRead_i  = 1'b1;
        MemWrite_i = 1'b1;
        Funct3_i   = 3'b010;
        Addr_i     = 9'h011;
        WData_i    = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset      = 1'b0;
        load_img   = 1'b0;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        mem_cmp("init");

        for (int i = 0; i < NV; i++)
            access(tv[i].rd, tv[i].wr, tv[i].f3, tv[i].a, tv[i].wd,
                   tv[i].cyc, tv[i].exp, $sformatf("vec%0d", i));

        // Reset in the second cycle of a split SW keeps only byte 0.
        MemWrite_i = 1'b1;
        Funct3_i   = 3'b010;
        Addr_i     = 9'h041;
        WData_i    = 32'h1122_3344;
        #1;
        chk("abort/stall0", 32'(stall), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        reset      = 1'b0;
        MemWrite_i = 1'b0;
        #1;
        chk("abort/stall_after", 32'(stall), 32'd0);
        chk("abort/misalign_after", 32'(misalign), 32'd0);
        chk("abort/memwrite_after", 32'(MemWrite_o), 32'd0);
        refm[9'h041] = 8'h44;
        mem_cmp("abort");
        @(negedge clk);
        access(1'b1, 1'b0, 3'b010, 9'h040, 32'h0, 1,
               ref_load(3'b010, 9'h040), "abort/reload");

        for (int i = 0; i < 300; i++) begin
            int sel;
            logic rd, wr;
            logic [2:0] f3;
            logic [8:0] a;
            logic [31:0] wd;
            sel = $urandom_range(0, 9);
            rd  = (sel <= 4);
            wr  = (sel >= 4 && sel <= 8);
            f3  = 3'($urandom);
            a   = 9'($urandom);
            wd  = $urandom;
            access(rd, wr, f3, a, wd, exp_cycles(rd, wr, f3, a),
                   rd ? ref_load(f3, a) : 32'd0, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
